// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory handshake and datapath/decoder signals.
// The master side is the fetch unit itself. The slave side is the environment,
// meaning instruction memory plus the decoder/datapath.
interface fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        ImemAck;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic        InstrValid;
    logic        Retire;
    logic        Branch;
    logic        Zero;
    logic        Jump;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchErr;

    modport master (
        output ImemReq, ImemAddr, Instr, Op, InstrValid, PC, PCPlus4, FetchErr,
        input  ImemData, ImemAck, Retire, Branch, Zero, Jump
    );

    modport slave (
        input  ImemReq, ImemAddr, Instr, Op, InstrValid, PC, PCPlus4, FetchErr,
        output ImemData, ImemAck, Retire, Branch, Zero, Jump
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It holds the PC, reads one word per instruction over
// a req/ack handshake, and presents the word to the decoder until retire. It then
// steps the PC to the sequential, beq or jump target.
// A memory that never acks parks the unit in a sticky error state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  wait_cnt;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Next-PC selection for the retire cycle: jump beats a taken branch, which beats sequential.
    always_comb begin
        // NOTE: assign the default first so every path drives next_pc and no latch is inferred.
        next_pc = pc_plus4;
        if (bus.Jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (bus.Branch && bus.Zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // Fetch FSM with its registered PC, instruction word, valid flag and sticky error.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    // An ack arriving on the last allowed wait cycle still counts.
                    if (bus.ImemAck) begin
                        instr       <= bus.ImemData;
                        wait_cnt    <= '0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        fetch_err   <= 1'b1;
                        state       <= ERROR;
                    end else begin
                        wait_cnt    <= wait_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (bus.Retire) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                ERROR: begin
                    // Only Reset leaves this state.
                    state <= ERROR;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // Reset must kill the request in the same cycle, so ImemReq is gated combinationally.
    assign bus.ImemReq    = (state == FETCH) && !Reset;
    assign bus.ImemAddr   = pc;
    assign bus.Instr      = instr;
    assign bus.Op         = instr[31:26];
    assign bus.InstrValid = instr_valid;
    assign bus.PC         = pc;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.FetchErr   = fetch_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. It runs directed steps for the spec corner cases,
// followed by randomized fetch/issue/retire traffic.
// The traffic is checked against an arithmetic PC model. A second instance sits
// at a high reset PC so jumps into region 4 can be reached.
module tb_fetch_unit;
    localparam logic [31:0] RST_A  = 32'h0000_0000;
    localparam logic [31:0] RST_HI = 32'h4000_0020;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    fetch_unit_if bus();
    fetch_unit_if bus_hi();

    fetch_unit #(.RESET_PC(RST_A), .TIMEOUT(4)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(RST_HI), .TIMEOUT(16)) u_dut_hi (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_hi)
    );

    // Free-running clock, 10 time-unit period.
    always #5 Clk = ~Clk;

    // Stop a runaway bench.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge Clk);
    endtask

    // Reference next-PC rule expressed as plain 32-bit arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic j, input logic b, input logic z);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b && z) begin
            off = int'($signed(ins[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        check("req_during_reset", 32'(bus.ImemReq), 32'd0);
        Reset = 1'b0;
        #1;
        exp_pc = RST_A;
    endtask

    // Fetch one word after 'waits' no-ack cycles. Retire/jump noise is applied meanwhile and must be ignored.
    task automatic fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            bus.ImemAck = 1'b0;
            bus.Retire  = 1'($urandom_range(0, 1));
            bus.Jump    = 1'($urandom_range(0, 1));
            bus.Branch  = 1'($urandom_range(0, 1));
            bus.Zero    = 1'($urandom_range(0, 1));
            check("wait_req", 32'(bus.ImemReq), 32'd1);
            check("wait_addr", bus.ImemAddr, exp_pc);
            tick();
        end
        check("fetch_req", 32'(bus.ImemReq), 32'd1);
        check("fetch_addr", bus.ImemAddr, exp_pc);
        check("fetch_invalid", 32'(bus.InstrValid), 32'd0);
        bus.ImemAck  = 1'b1;
        bus.ImemData = word;
        bus.Retire   = 1'($urandom_range(0, 1));
        tick();
        bus.ImemAck  = 1'b0;
        bus.ImemData = $urandom;
        bus.Retire   = 1'b0;
        exp_instr    = word;
        check("issue_valid", 32'(bus.InstrValid), 32'd1);
        check("issue_instr", bus.Instr, word);
        check("issue_op", 32'(bus.Op), 32'(word[31:26]));
        check("issue_req", 32'(bus.ImemReq), 32'd0);
        check("issue_pc", bus.PC, exp_pc);
        check("issue_pcplus4", bus.PCPlus4, exp_pc + 32'd4);
    endtask

    // Stay in ISSUE with Retire low. Acks and branch/jump noise must not disturb anything.
    task automatic issue_hold(input int n);
        for (int i = 0; i < n; i++) begin
            bus.Retire   = 1'b0;
            bus.ImemAck  = 1'($urandom_range(0, 1));
            bus.ImemData = $urandom;
            bus.Jump     = 1'($urandom_range(0, 1));
            bus.Branch   = 1'($urandom_range(0, 1));
            bus.Zero     = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", 32'(bus.InstrValid), 32'd1);
            check("hold_instr", bus.Instr, exp_instr);
            check("hold_pc", bus.PC, exp_pc);
            check("hold_req", 32'(bus.ImemReq), 32'd0);
        end
        bus.ImemAck = 1'b0;
    endtask

    task automatic retire(input logic j, input logic b, input logic z);
        bus.Jump    = j;
        bus.Branch  = b;
        bus.Zero    = z;
        bus.Retire  = 1'b1;
        bus.ImemAck = 1'($urandom_range(0, 1));
        tick();
        bus.Retire  = 1'b0;
        bus.ImemAck = 1'b0;
        bus.Jump    = 1'b0;
        bus.Branch  = 1'b0;
        bus.Zero    = 1'b0;
        exp_pc = model_next(exp_pc, exp_instr, j, b, z);
        check("retire_req", 32'(bus.ImemReq), 32'd1);
        check("retire_addr", bus.ImemAddr, exp_pc);
        check("retire_invalid", 32'(bus.InstrValid), 32'd0);
        check("retire_op_held", 32'(bus.Op), 32'(exp_instr[31:26]));
    endtask

    initial begin
        Reset = 1'b1;
        bus.ImemData = '0; bus.ImemAck = 1'b0; bus.Retire = 1'b0;
        bus.Branch = 1'b0; bus.Zero = 1'b0; bus.Jump = 1'b0;
        bus_hi.ImemData = '0; bus_hi.ImemAck = 1'b0; bus_hi.Retire = 1'b0;
        bus_hi.Branch = 1'b0; bus_hi.Zero = 1'b0; bus_hi.Jump = 1'b0;
        exp_pc = RST_A;
        exp_instr = '0;

        // High-region instance: reset PC, then a jump that also has a taken branch.
        tick();
        Reset = 1'b0;
        #1;
        check("hi_reset_addr", bus_hi.ImemAddr, RST_HI);
        check("hi_reset_req", 32'(bus_hi.ImemReq), 32'd1);
        bus_hi.ImemAck = 1'b1; bus_hi.ImemData = 32'h0800_0100;
        tick();
        bus_hi.ImemAck = 1'b0;
        check("hi_valid", 32'(bus_hi.InstrValid), 32'd1);
        bus_hi.Jump = 1'b1; bus_hi.Branch = 1'b1; bus_hi.Zero = 1'b1; bus_hi.Retire = 1'b1;
        tick();
        bus_hi.Jump = 1'b0; bus_hi.Branch = 1'b0; bus_hi.Zero = 1'b0; bus_hi.Retire = 1'b0;
        check("hi_jump_priority", bus_hi.ImemAddr, 32'h4000_0400);
        bus_hi.ImemAck = 1'b1; bus_hi.ImemData = 32'h2002_0001;
        tick();
        bus_hi.ImemAck = 1'b0;
        Reset = 1'b1;
        tick();
        check("hi_reset_issue_valid", 32'(bus_hi.InstrValid), 32'd0);
        check("hi_reset_issue_pc", bus_hi.PC, RST_HI);

        // Reset state of the main instance.
        do_reset();
        check("rst_req", 32'(bus.ImemReq), 32'd1);
        check("rst_addr", bus.ImemAddr, RST_A);
        check("rst_instr", bus.Instr, 32'h0);
        check("rst_valid", 32'(bus.InstrValid), 32'd0);
        check("rst_err", 32'(bus.FetchErr), 32'd0);
        check("rst_pcplus4", bus.PCPlus4, 32'h4);

        // Zero-wait lw, then sequential retire.
        fetch(32'h8C22_0004, 0);
        check("lw_op", 32'(bus.Op), 32'h23);
        retire(1'b0, 1'b0, 1'b0);
        check("lw_next_addr", bus.ImemAddr, 32'h4);

        // beq taken and not taken at PC 0x10.
        fetch(32'h0800_0004, 0);
        retire(1'b1, 1'b0, 1'b0);
        check("jump_to_10", bus.ImemAddr, 32'h10);
        fetch(32'h1000_FFFE, 0);
        retire(1'b0, 1'b1, 1'b1);
        check("beq_taken", bus.ImemAddr, 32'h0C);
        fetch(32'h0800_0004, 0);
        retire(1'b1, 1'b0, 1'b0);
        fetch(32'h1000_FFFE, 0);
        retire(1'b0, 1'b1, 1'b0);
        check("beq_not_taken", bus.ImemAddr, 32'h14);

        // Three wait states with the ack landing on the last allowed cycle, then a long hold.
        fetch(32'h2002_0001, 3);
        issue_hold(5);
        retire(1'b0, 1'b0, 1'b1);
        check("zero_only_seq", bus.ImemAddr, 32'h18);

        // Reset while in ISSUE at PC 0x20.
        fetch(32'h0800_0008, 0);
        retire(1'b1, 1'b0, 1'b0);
        fetch(32'hAC01_0008, 0);
        check("pc_is_20", bus.PC, 32'h20);
        Reset = 1'b1;
        tick();
        check("rst_issue_valid", 32'(bus.InstrValid), 32'd0);
        check("rst_issue_pc", bus.PC, RST_A);
        Reset = 1'b0;
        #1;
        exp_pc = RST_A;

        // Wrap case: branch back to 0xFFFF_FFFC, then sequential wraps to 0.
        fetch(32'h1000_FFFE, 0);
        retire(1'b0, 1'b1, 1'b1);
        check("branch_to_top", bus.ImemAddr, 32'hFFFF_FFFC);
        fetch(32'h2002_0001, 1);
        retire(1'b0, 1'b0, 1'b0);
        check("wrap_addr", bus.ImemAddr, 32'h0);

        // Reset in mid-FETCH abandons the request and restarts the wait count.
        do_reset();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        check("rst_fetch_req", 32'(bus.ImemReq), 32'd1);
        check("rst_fetch_addr", bus.ImemAddr, RST_A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_fetch_cnt_cleared", 32'(bus.ImemReq), 32'd1);
        end

        // Timeout: four no-ack FETCH cycles lead to ERROR, which only Reset leaves.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tmo_still_fetch", 32'(bus.ImemReq), 32'd1);
            check("tmo_no_err_yet", 32'(bus.FetchErr), 32'd0);
        end
        tick();
        check("tmo_err", 32'(bus.FetchErr), 32'd1);
        check("tmo_req", 32'(bus.ImemReq), 32'd0);
        check("tmo_valid", 32'(bus.InstrValid), 32'd0);
        bus.ImemAck = 1'b1; bus.ImemData = 32'hDEAD_BEEF; bus.Retire = 1'b1; bus.Jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_sticky", 32'(bus.FetchErr), 32'd1);
            check("err_no_req", 32'(bus.ImemReq), 32'd0);
            check("err_no_valid", 32'(bus.InstrValid), 32'd0);
            check("err_pc_held", bus.PC, RST_A);
        end
        bus.ImemAck = 1'b0; bus.Retire = 1'b0; bus.Jump = 1'b0;
        do_reset();
        check("err_cleared", 32'(bus.FetchErr), 32'd0);
        check("err_reset_addr", bus.ImemAddr, RST_A);

        // Randomized traffic against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            fetch($urandom, int'($urandom_range(0, 3)));
            issue_hold(int'($urandom_range(0, 3)));
            retire(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
